bpu_update_unit: RTL

- Receives `bpu_update_t` correction packets and turns them into write-port transactions on the BPU tables (BTB, BHT, LPHT).
- Two packet sources:
  - the pre-decode fixer (front, bogus-taken correction);
  - the back-end branch-resolve stage (back).
- Packets are buffered in a small queue, then applied through a 2-stage read-modify-write pipeline.
- Sits between the fetch/decode correction logic plus the execute stage, and the predictor storage.

---
 rtl/bpu_update_unit_if.sv | 42 ++++
 rtl/bpu_update_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bpu_update_unit_if.sv
// ----------------------------------------------------------------------------
// bpu_update_unit_if
//   One BPU correction packet source (pre-decode fixer or branch resolve).
//   The packet is valid while flush=1; ready is returned by the update unit.
//
//   flush       packet valid
//   pc          branch pc (byte address)
//   br_taken    resolved direction
//   br_target   resolved target (byte address)
//   br_type     branch type written to the BTB
//   lphr        current LPHT 2-bit counter value
//   lphr_index  LPHT entry to write
//   btb_update / bht_update / lpht_update   per-table enables
//   ready       unit can take a packet from this source this cycle
// ----------------------------------------------------------------------------
interface bpu_update_unit_if #(
    parameter int unsigned LPHT_ADDR_W = 5
);
    logic                   flush;
    logic [31:0]            pc;
    logic                   br_taken;
    logic [31:0]            br_target;
    logic [1:0]             br_type;
    logic [1:0]             lphr;
    logic [LPHT_ADDR_W-1:0] lphr_index;
    logic                   btb_update;
    logic                   bht_update;
    logic                   lpht_update;
    logic                   ready;

    modport master (
        output flush, pc, br_taken, br_target, br_type, lphr, lphr_index,
               btb_update, bht_update, lpht_update,
        input  ready
    );

    modport slave (
        input  flush, pc, br_taken, br_target, br_type, lphr, lphr_index,
               btb_update, bht_update, lpht_update,
        output ready
    );
endinterface

// File: rtl/bpu_update_unit.sv
// ----------------------------------------------------------------------------
// bpu_update_unit
//   Buffers BPU correction packets from the front (pre-decode fixer) and back
//   (branch resolve) sources in a small FIFO and applies them to the BTB, BHT
//   and LPHT through a 2-stage read-modify-write pipeline (S1 read, S2 write).
//
//   Optional build macro: BPU_UPD_STATS_EN adds saturating 32-bit counters
//   front_drop_cnt_o and upd_done_cnt_o.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   front_upd_i         front packet source (ready = two or more free slots)
//   back_upd_i          back packet source  (ready = back_ready_o)
//   back_ready_o        queue can accept a back packet this cycle
//   bht_raddr_o         BHT synchronous read address (data returns next cycle)
//   bht_rdata_i         BHT read data
//   bht_*_o             BHT write port  (history shift register)
//   lpht_*_o            LPHT write port (2-bit saturating counter)
//   btb_*_o             BTB write port  (tag, word target, type)
//   busy_o              queue non-empty or pipeline occupied
// ----------------------------------------------------------------------------
module bpu_update_unit #(
    parameter int unsigned QDEPTH      = 4,
    parameter int unsigned BHT_ADDR_W  = 7,
    parameter int unsigned HISTORY_W   = 5,
    parameter int unsigned LPHT_ADDR_W = 5,
    parameter int unsigned BTB_ADDR_W  = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef BPU_UPD_STATS_EN
    output logic [31:0]             front_drop_cnt_o,
    output logic [31:0]             upd_done_cnt_o,
`endif
    bpu_update_unit_if.slave        front_upd_i,
    bpu_update_unit_if.slave        back_upd_i,
    output logic                    back_ready_o,
    output logic [BHT_ADDR_W-1:0]   bht_raddr_o,
    input  logic [HISTORY_W-1:0]    bht_rdata_i,
    output logic                    bht_we_o,
    output logic [BHT_ADDR_W-1:0]   bht_waddr_o,
    output logic [HISTORY_W-1:0]    bht_wdata_o,
    output logic                    lpht_we_o,
    output logic [LPHT_ADDR_W-1:0]  lpht_waddr_o,
    output logic [1:0]              lpht_wdata_o,
    output logic                    btb_we_o,
    output logic [BTB_ADDR_W-1:0]   btb_waddr_o,
    output logic [29-BTB_ADDR_W:0]  btb_wtag_o,
    output logic [29:0]             btb_wtarget_o,
    output logic [1:0]              btb_wtype_o,
    output logic                    busy_o
);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]            pc;
        logic                   br_taken;
        logic [31:0]            br_target;
        logic [1:0]             br_type;
        logic [1:0]             lphr;
        logic [LPHT_ADDR_W-1:0] lphr_index;
        logic                   btb_update;
        logic                   bht_update;
        logic                   lpht_update;
    } bpu_update_t;

    bpu_update_t w_front_pkt, w_back_pkt;

    assign w_front_pkt = '{pc: front_upd_i.pc, br_taken: front_upd_i.br_taken,
                           br_target: front_upd_i.br_target, br_type: front_upd_i.br_type,
                           lphr: front_upd_i.lphr, lphr_index: front_upd_i.lphr_index,
                           btb_update: front_upd_i.btb_update,
                           bht_update: front_upd_i.bht_update,
                           lpht_update: front_upd_i.lpht_update};
    assign w_back_pkt  = '{pc: back_upd_i.pc, br_taken: back_upd_i.br_taken,
                           br_target: back_upd_i.br_target, br_type: back_upd_i.br_type,
                           lphr: back_upd_i.lphr, lphr_index: back_upd_i.lphr_index,
                           btb_update: back_upd_i.btb_update,
                           bht_update: back_upd_i.bht_update,
                           lpht_update: back_upd_i.lpht_update};

    // ---------------- queue ----------------
    bpu_update_t      r_q [QDEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr, w_front_idx;
    logic [CNT_W-1:0] r_count, w_free;
    logic             w_pop, w_back_acc, w_front_acc;

    // S2 never stalls, so S1 always advances and the head pops whenever present.
    assign w_pop        = (r_count != '0);
    assign w_free       = CNT_W'(QDEPTH) - r_count + CNT_W'(w_pop);
    assign back_ready_o = (w_free != '0);
    // Front needs two free slots so it can never take the last one from the back.
    assign front_upd_i.ready = (w_free >= CNT_W'(2));
    assign back_upd_i.ready  = back_ready_o;
    assign w_back_acc   = back_upd_i.flush && back_ready_o;
    assign w_front_acc  = front_upd_i.flush && front_upd_i.ready;
    assign w_front_idx  = r_wptr + PTR_W'(w_back_acc);

    always_ff @(posedge clk) begin
        if (w_back_acc)  r_q[r_wptr]      <= w_back_pkt;
        if (w_front_acc) r_q[w_front_idx] <= w_front_pkt;
    end

    // ---------------- pipeline ----------------
    bpu_update_t           r_s1, r_s2;
    logic                  r_s1_valid, r_s2_valid;
    logic                  r_fwd_valid;
    logic [BHT_ADDR_W-1:0] r_fwd_idx, w_s2_idx;
    logic [HISTORY_W-1:0]  r_fwd_hist, w_hist, w_newhist;
    logic [1:0]            w_lpht_new;
    logic                  w_bht_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_idx   <= '0;
            r_fwd_hist  <= '0;
        end else begin
            r_wptr  <= w_front_idx + PTR_W'(w_front_acc);
            r_rptr  <= r_rptr + PTR_W'(w_pop);
            r_count <= r_count + CNT_W'(w_back_acc) + CNT_W'(w_front_acc) - CNT_W'(w_pop);
            r_s1_valid <= w_pop;
            if (w_pop) r_s1 <= r_q[r_rptr];
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_s2 <= r_s1;
            // The BHT read for the following packet was issued in the same cycle as
            // this write, so its returned data may be stale: keep the new value.
            r_fwd_valid <= w_bht_we;
            r_fwd_idx   <= w_s2_idx;
            r_fwd_hist  <= w_newhist;
        end
    end

    assign bht_raddr_o = r_s1.pc[BHT_ADDR_W+1:2];
    assign w_s2_idx    = r_s2.pc[BHT_ADDR_W+1:2];
    assign w_hist      = (r_fwd_valid && (r_fwd_idx == w_s2_idx)) ? r_fwd_hist : bht_rdata_i;
    assign w_newhist   = {w_hist[HISTORY_W-2:0], r_s2.br_taken};

    always_comb begin
        w_lpht_new = r_s2.lphr;
        if (r_s2.br_taken) begin
            if (r_s2.lphr != 2'b11) w_lpht_new = r_s2.lphr + 2'd1;
        end else begin
            if (r_s2.lphr != 2'b00) w_lpht_new = r_s2.lphr - 2'd1;
        end
    end

    // Write ports are held at zero except during their one-cycle pulse.
    assign w_bht_we      = r_s2_valid && r_s2.bht_update;
    assign bht_we_o      = w_bht_we;
    assign bht_waddr_o   = w_bht_we ? w_s2_idx : '0;
    assign bht_wdata_o   = w_bht_we ? w_newhist : '0;
    assign lpht_we_o     = r_s2_valid && r_s2.lpht_update;
    assign lpht_waddr_o  = lpht_we_o ? r_s2.lphr_index : '0;
    assign lpht_wdata_o  = lpht_we_o ? w_lpht_new : '0;
    assign btb_we_o      = r_s2_valid && r_s2.btb_update;
    assign btb_waddr_o   = btb_we_o ? r_s2.pc[BTB_ADDR_W+1:2] : '0;
    assign btb_wtag_o    = btb_we_o ? r_s2.pc[31:BTB_ADDR_W+2] : '0;
    assign btb_wtarget_o = btb_we_o ? r_s2.br_target[31:2] : '0;
    assign btb_wtype_o   = btb_we_o ? r_s2.br_type : '0;

    assign busy_o = (r_count != '0) || r_s1_valid || r_s2_valid;

    logic w_unused;
    assign w_unused = ^{r_s2.pc[1:0], r_s2.br_target[1:0]};

`ifdef BPU_UPD_STATS_EN
    logic [31:0] r_front_drop_cnt, r_upd_done_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front_drop_cnt <= '0;
            r_upd_done_cnt   <= '0;
        end else begin
            if (front_upd_i.flush && !w_front_acc && (r_front_drop_cnt != '1))
                r_front_drop_cnt <= r_front_drop_cnt + 32'd1;
            if (r_s2_valid && (r_upd_done_cnt != '1))
                r_upd_done_cnt <= r_upd_done_cnt + 32'd1;
        end
    end

    assign front_drop_cnt_o = r_front_drop_cnt;
    assign upd_done_cnt_o   = r_upd_done_cnt;
`endif
endmodule
